// File: rtl/store_merge_unit.sv
// -----------------------------------------------------------------------------
// store_merge_unit
//
// Write side of the data-memory interface in the memory stage. Aligns store
// data to its little-endian byte lane and drives a word-wide synchronous
// memory. Since the memory has no byte enables, byte and halfword stores run
// a two-cycle read-modify-write:
//   - IDLE: the word is read and the pipeline is stalled.
//   - MERGE: the new lanes are merged into the returned word, which is
//     written back.
// Word stores and load-address passthrough take a single cycle in IDLE.
//
// Optional build macro: STORE_BYTE_ENABLE_EN
//   When defined, the memory honours outMemBe. Every aligned store then
//   completes in one cycle with replicated write data and a lane mask, and
//   the MERGE state is never entered.
//
// Handshake: inMemWrite is a level request that the pipeline holds for as
// long as outStall=1. A request is consumed in the cycle where outStall=0:
//   - directly in IDLE for word or misaligned stores, or
//   - in MERGE for partial stores.
// Inputs are ignored while in MERGE.
//
// Ports:
//   clk, rst       clock (rising edge), synchronous active-high reset
//   inMemWrite     store request
//   inMemRead      load request (address passthrough only)
//   inStoreSize    00 word, 01 byte, 10 halfword, 11 treated as word
//   inAddr         byte address
//   inStoreData    store data, right-justified
//   inMemRd        memory read data, one cycle after address
//   outMemAddr     word address to memory (inAddr[AW+1:2] unless merging)
//   outMemWe       memory write strobe
//   outMemWd       memory write data
//   outMemBe       byte enables (4'hF unless STORE_BYTE_ENABLE_EN)
//   outStall       freeze upstream pipeline registers
//   outMisaligned  address exception pulse, store suppressed
// -----------------------------------------------------------------------------
module store_merge_unit #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inMemWrite,
    input  logic          inMemRead,
    input  logic [1:0]    inStoreSize,
    input  logic [31:0]   inAddr,
    input  logic [31:0]   inStoreData,
    input  logic [31:0]   inMemRd,
    output logic [AW-1:0] outMemAddr,
    output logic          outMemWe,
    output logic [31:0]   outMemWd,
    output logic [3:0]    outMemBe,
    output logic          outStall,
    output logic          outMisaligned
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_MERGE = 1'b1;

    localparam logic [1:0] SZ_BYTE = 2'b01;
    localparam logic [1:0] SZ_HALF = 2'b10;

    logic [0:0]    state_q, state_d;
    logic [AW-1:0] addr_q,  addr_d;
    logic [1:0]    lane_q,  lane_d;
    logic [1:0]    size_q,  size_d;
    logic [31:0]   data_q,  data_d;

    logic          is_byte, is_half, is_word, misaligned;
    logic [AW-1:0] addr_word;
    logic [1:0]    lane;

    // Loads need only the address; their data is consumed downstream.
    logic unused_inputs;
    assign unused_inputs = ^{inMemRead, inAddr[31:AW+2]};

    assign is_byte    = (inStoreSize == SZ_BYTE);
    assign is_half    = (inStoreSize == SZ_HALF);
    assign is_word    = !is_byte && !is_half;   // 2'b11 behaves as word
    assign lane       = inAddr[1:0];
    assign addr_word  = inAddr[AW+1:2];
    assign misaligned = (is_word && (lane != 2'b00)) || (is_half && lane[0]);

    // Overlay the latched store bytes onto the word returned by memory.
    function automatic logic [31:0] merge_word(
        input logic [31:0] old_word,
        input logic [31:0] data,
        input logic [1:0]  ln,
        input logic [1:0]  sz
    );
        logic [31:0] r;
        r = old_word;
        if (sz == SZ_HALF) begin
            if (ln[1]) r[31:16] = data[15:0];
            else       r[15:0]  = data[15:0];
        end else begin
            r[{ln, 3'b000} +: 8] = data[7:0];
        end
        return r;
    endfunction

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        lane_d        = lane_q;
        size_d        = size_q;
        data_d        = data_q;
        outMemAddr    = addr_word;
        outMemWe      = 1'b0;
        outMemWd      = 32'h0;
        outMemBe      = 4'hF;
        outStall      = 1'b0;
        outMisaligned = 1'b0;

        if (state_q == ST_IDLE) begin
            // A write takes priority over a simultaneous read.
            if (inMemWrite) begin
                if (misaligned) begin
                    outMisaligned = 1'b1;
                end else if (is_word) begin
                    outMemWe = 1'b1;
                    outMemWd = inStoreData;
                end else begin
`ifdef STORE_BYTE_ENABLE_EN
                    outMemWe = 1'b1;
                    if (is_byte) begin
                        outMemWd = {4{inStoreData[7:0]}};
                        outMemBe = 4'b0001 << lane;
                    end else begin
                        outMemWd = {2{inStoreData[15:0]}};
                        outMemBe = 4'b0011 << lane;
                    end
`else
                    // Read the target word now; write the merged word next cycle.
                    outStall = 1'b1;
                    state_d  = ST_MERGE;
                    addr_d   = addr_word;
                    lane_d   = lane;
                    size_d   = inStoreSize;
                    data_d   = inStoreData;
`endif
                end
            end
        end else begin
            outMemAddr = addr_q;
            outMemWe   = 1'b1;
            outMemWd   = merge_word(inMemRd, data_q, lane_q, size_q);
            state_d    = ST_IDLE;
        end

        // Reset cancels any in-flight merge write and forces idle outputs.
        if (rst) begin
            outMemAddr    = addr_word;
            outMemWe      = 1'b0;
            outMemWd      = 32'h0;
            outMemBe      = 4'hF;
            outStall      = 1'b0;
            outMisaligned = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            lane_q  <= 2'b00;
            size_q  <= 2'b00;
            data_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            lane_q  <= lane_d;
            size_q  <= size_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: tb/tb_store_merge_unit.sv
module tb_store_merge_unit;

    localparam int AW = 10;
    localparam int NW = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          inMemWrite;
    logic          inMemRead;
    logic [1:0]    inStoreSize;
    logic [31:0]   inAddr;
    logic [31:0]   inStoreData;
    logic [31:0]   inMemRd;
    logic [AW-1:0] outMemAddr;
    logic          outMemWe;
    logic [31:0]   outMemWd;
    logic [3:0]    outMemBe;
    logic          outStall;
    logic          outMisaligned;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_q[$];            // expected outMemWd per write strobe
    logic [31:0] exp_mem [0:NW-1];    // reference memory image
    logic        stall_hist[$];
    logic [31:0] mem [0:NW-1];        // harness memory

    store_merge_unit #(.AW(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .inMemWrite   (inMemWrite),
        .inMemRead    (inMemRead),
        .inStoreSize  (inStoreSize),
        .inAddr       (inAddr),
        .inStoreData  (inStoreData),
        .inMemRd      (inMemRd),
        .outMemAddr   (outMemAddr),
        .outMemWe     (outMemWe),
        .outMemWd     (outMemWd),
        .outMemBe     (outMemBe),
        .outStall     (outStall),
        .outMisaligned(outMisaligned)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- synchronous memory honouring byte enables ----------------
    always @(posedge clk) begin : mem_blk
        logic [31:0] w;
        inMemRd <= mem[outMemAddr];
        if (outMemWe) begin
            w = mem[outMemAddr];
            for (int k = 0; k < 4; k++)
                if (outMemBe[k]) w[8*k +: 8] = outMemWd[8*k +: 8];
            mem[outMemAddr] <= w;
        end
    end

    // ---------------- write-strobe scoreboard ----------------
    always @(negedge clk) begin
        if (outMemWe === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_we: addr=%0h wd=%08h, no write expected", outMemAddr, outMemWd);
            end else begin : pop_blk
                logic [31:0] e;
                e = exp_q.pop_front();
                if (outMemWd !== e) begin
                    failures++;
                    $display("FAIL write_data: got %08h expected %08h", outMemWd, e);
                end
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic logic is_misaligned(input logic [1:0] size, input logic [31:0] addr);
        if (size == 2'b01) return 1'b0;
        if (size == 2'b10) return addr[0];
        return addr[1:0] != 2'b00;
    endfunction

    function automatic int size_bytes(input logic [1:0] size);
        if (size == 2'b01) return 1;
        if (size == 2'b10) return 2;
        return 4;
    endfunction

    // Little-endian memory image after storing size_bytes(size) bytes at lane.
    function automatic logic [31:0] model_store(input logic [31:0] old_word, input logic [1:0] size,
                                                input logic [1:0] lane, input logic [31:0] data);
        logic [7:0]  b [4];
        logic [31:0] r;
        int          l;
        l = int'(lane);
        for (int i = 0; i < 4; i++) b[i] = old_word[8*i +: 8];
        for (int k = 0; k < size_bytes(size); k++) b[l + k] = data[8*k +: 8];
        for (int i = 0; i < 4; i++) r[8*i +: 8] = b[i];
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            inMemWrite = 1'b0;
            inMemRead  = 1'b0;
            @(negedge clk);
            checks++;
            if ({outMemWe, outStall, outMisaligned} !== 3'b000) begin
                failures++;
                $display("FAIL idle_outputs: we/stall/mis=%b expected 000", {outMemWe, outStall, outMisaligned});
            end
        end
    endtask

    // Issues one store, holding it through any stall, and checks each cycle.
    task automatic do_store(input logic [1:0] size, input logic [31:0] addr,
                            input logic [31:0] data, input logic rd);
        logic          mis, partial, exp_we, exp_stall;
        logic [AW-1:0] widx;
        logic [31:0]   newv;
        logic [3:0]    exp_be;
        mis     = is_misaligned(size, addr);
        partial = !mis && (size_bytes(size) < 4);
        widx    = addr[AW+1:2];
        newv    = model_store(exp_mem[widx], size, addr[1:0], data);
        exp_be  = 4'hF;
`ifdef STORE_BYTE_ENABLE_EN
        exp_we    = !mis;
        exp_stall = 1'b0;
        if (!mis && size_bytes(size) == 1) exp_be = 4'b0001 << addr[1:0];
        if (!mis && size_bytes(size) == 2) exp_be = 4'b0011 << addr[1:0];
`else
        exp_we    = !mis && !partial;
        exp_stall = partial;
`endif
        @(posedge clk); #1;
        inMemWrite  = 1'b1;
        inMemRead   = rd;
        inStoreSize = size;
        inAddr      = addr;
        inStoreData = data;
        if (exp_we) begin
`ifdef STORE_BYTE_ENABLE_EN
            if (size_bytes(size) == 1)      exp_q.push_back({4{data[7:0]}});
            else if (size_bytes(size) == 2) exp_q.push_back({2{data[15:0]}});
            else                            exp_q.push_back(data);
`else
            exp_q.push_back(data);
`endif
        end
        @(negedge clk);
        stall_hist.push_back(outStall);
        checks++;
        if (outMisaligned !== mis || outMemWe !== exp_we || outStall !== exp_stall) begin
            failures++;
            $display("FAIL store_cycle0: sz=%0d a=%08h mis/we/stall=%b%b%b expected %b%b%b", size, addr,
                     outMisaligned, outMemWe, outStall, mis, exp_we, exp_stall);
        end
        checks++;
        if (outMemAddr !== widx || outMemBe !== exp_be) begin
            failures++;
            $display("FAIL store_addr_be: addr=%0h be=%h expected %0h %h", outMemAddr, outMemBe, widx, exp_be);
        end
        if (exp_stall) begin
            exp_q.push_back(newv);
            @(posedge clk); #1;
            @(negedge clk);
            stall_hist.push_back(outStall);
            checks++;
            if (outMemWe !== 1'b1 || outStall !== 1'b0 || outMisaligned !== 1'b0 || outMemAddr !== widx) begin
                failures++;
                $display("FAIL merge_cycle: we/stall/mis=%b%b%b addr=%0h expected 100 %0h",
                         outMemWe, outStall, outMisaligned, outMemAddr, widx);
            end
        end
        if (!mis) exp_mem[widx] = newv;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        rst         = 1'b1;
        inMemWrite  = 1'b1;
        inMemRead   = 1'b0;
        inStoreSize = 2'b01;
        inAddr      = $urandom;
        inStoreData = $urandom;
        @(posedge clk); @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({outMemWe, outStall, outMisaligned} !== 3'b000 || outMemBe !== 4'hF || outMemWd !== 32'h0) begin
            failures++;
            $display("FAIL reset_outputs: we/stall/mis=%b be=%h wd=%08h expected 000 f 0",
                     {outMemWe, outStall, outMisaligned}, outMemBe, outMemWd);
        end
        checks++;
        if (outMemAddr !== inAddr[AW+1:2]) begin
            failures++;
            $display("FAIL reset_addr: got %0h expected %0h", outMemAddr, inAddr[AW+1:2]);
        end
        @(posedge clk); #1;
        rst        = 1'b0;
        inMemWrite = 1'b0;
        idle(1);
    endtask

    task automatic test_word;
        do_store(2'b00, 32'h10, 32'hAABBCCDD, 1'b0);
        do_store(2'b00, 32'h14, 32'hDEADBEEF, 1'b1);
        idle(1);
        checks++;
        if (mem[5] !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL word_store_mem: got %08h expected deadbeef", mem[5]);
        end
    endtask

    task automatic test_byte;
        do_store(2'b01, 32'h11, 32'h12345677, 1'b0);
        idle(1);
        checks++;
        if (mem[4] !== 32'hAABB77DD) begin
            failures++;
            $display("FAIL byte_store_mem: got %08h expected aabb77dd", mem[4]);
        end
    endtask

    task automatic test_half;
        do_store(2'b00, 32'h10, 32'hAABBCCDD, 1'b0);
        stall_hist.delete();
        do_store(2'b10, 32'h12, 32'h0000BEEF, 1'b0);
        idle(1);
        checks++;
        if (mem[4] !== 32'hBEEFCCDD) begin
            failures++;
            $display("FAIL half_store_mem: got %08h expected beefccdd", mem[4]);
        end
`ifndef STORE_BYTE_ENABLE_EN
        checks++;
        if (stall_hist.size() != 2 || stall_hist[0] !== 1'b1 || stall_hist[1] !== 1'b0) begin
            failures++;
            $display("FAIL half_stall_count: entries=%0d expected pattern 1,0", stall_hist.size());
        end
`endif
    endtask

    task automatic test_misaligned;
        do_store(2'b10, 32'h13, 32'h00001234, 1'b0);
        do_store(2'b00, 32'h16, 32'h55667788, 1'b0);
        do_store(2'b11, 32'h11, 32'h99999999, 1'b0);
        idle(1);
        checks++;
        if (mem[4] !== 32'hBEEFCCDD || mem[5] !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL misaligned_mem: w4=%08h w5=%08h expected beefccdd deadbeef", mem[4], mem[5]);
        end
    endtask

    task automatic test_back_to_back;
        do_store(2'b00, 32'h10, 32'h0, 1'b0);
        stall_hist.delete();
        do_store(2'b01, 32'h10, 32'h11, 1'b0);
        do_store(2'b01, 32'h13, 32'h44, 1'b0);
        idle(1);
        checks++;
        if (mem[4] !== 32'h44000011) begin
            failures++;
            $display("FAIL b2b_mem: got %08h expected 44000011", mem[4]);
        end
`ifndef STORE_BYTE_ENABLE_EN
        checks++;
        if (stall_hist.size() != 4 || stall_hist[0] !== 1'b1 || stall_hist[1] !== 1'b0 ||
            stall_hist[2] !== 1'b1 || stall_hist[3] !== 1'b0) begin
            failures++;
            $display("FAIL b2b_stall_pattern: entries=%0d expected 1,0,1,0", stall_hist.size());
        end
`endif
    endtask

    task automatic test_read_passthrough;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            inMemWrite = 1'b0;
            inMemRead  = 1'b1;
            inAddr     = $urandom;
            @(negedge clk);
            checks++;
            if (outMemAddr !== inAddr[AW+1:2] || outMemWe !== 1'b0 || outStall !== 1'b0) begin
                failures++;
                $display("FAIL read_passthrough: addr=%0h we=%b stall=%b expected %0h 0 0",
                         outMemAddr, outMemWe, outStall, inAddr[AW+1:2]);
            end
        end
        idle(1);
    endtask

`ifndef STORE_BYTE_ENABLE_EN
    task automatic test_reset_in_merge;
        do_store(2'b00, 32'h10, 32'h5A5A5A5A, 1'b0);
        @(posedge clk); #1;
        inMemWrite  = 1'b1;
        inStoreSize = 2'b01;
        inAddr      = 32'h10;
        inStoreData = 32'h99;
        @(negedge clk);
        checks++;
        if (outStall !== 1'b1) begin
            failures++;
            $display("FAIL rim_stall: got %b expected 1", outStall);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({outMemWe, outStall, outMisaligned} !== 3'b000 || outMemWd !== 32'h0 ||
            outMemBe !== 4'hF || outMemAddr !== inAddr[AW+1:2]) begin
            failures++;
            $display("FAIL rim_reset_cycle: we/stall/mis=%b wd=%08h be=%h addr=%0h",
                     {outMemWe, outStall, outMisaligned}, outMemWd, outMemBe, outMemAddr);
        end
        @(posedge clk); #1;
        rst        = 1'b0;
        inMemWrite = 1'b0;
        @(negedge clk);
        checks++;
        if ({outMemWe, outStall, outMisaligned} !== 3'b000 || outMemWd !== 32'h0 || outMemBe !== 4'hF) begin
            failures++;
            $display("FAIL rim_after_reset: we/stall/mis=%b wd=%08h be=%h",
                     {outMemWe, outStall, outMisaligned}, outMemWd, outMemBe);
        end
        idle(1);
        checks++;
        if (mem[4] !== 32'h5A5A5A5A) begin
            failures++;
            $display("FAIL rim_mem: got %08h expected 5a5a5a5a", mem[4]);
        end
    endtask
`else
    task automatic test_byte_enable;
        @(posedge clk); #1;
        inMemWrite  = 1'b1;
        inStoreSize = 2'b01;
        inAddr      = 32'h12;
        inStoreData = 32'hAB;
        exp_q.push_back(32'hABABABAB);
        exp_mem[4]  = model_store(exp_mem[4], 2'b01, 2'b10, 32'hAB);
        @(negedge clk);
        checks++;
        if (outMemBe !== 4'b0100 || outMemWd !== 32'hABABABAB || outStall !== 1'b0 || outMemWe !== 1'b1) begin
            failures++;
            $display("FAIL byte_enable: be=%b wd=%08h stall=%b we=%b expected 0100 abababab 0 1",
                     outMemBe, outMemWd, outStall, outMemWe);
        end
        idle(1);
    endtask
`endif

    task automatic test_random;
        for (int w = 0; w < 8; w++) do_store(2'b00, w * 4, $urandom, 1'b0);
        for (int i = 0; i < 40; i++) begin
            do_store(2'($urandom_range(0, 3)), 32'($urandom_range(0, 31)), $urandom, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) idle(1);
        end
        idle(1);
        for (int w = 0; w < 8; w++) begin
            checks++;
            if (mem[w] !== exp_mem[w]) begin
                failures++;
                $display("FAIL random_mem[%0d]: got %08h expected %08h", w, mem[w], exp_mem[w]);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_misaligned();
        test_back_to_back();
        test_read_passthrough();
`ifndef STORE_BYTE_ENABLE_EN
        test_reset_in_merge();
`else
        test_byte_enable();
`endif
        test_random();
        idle(2);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL missing_writes: %0d expected writes never seen, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/store_merge_unit.md
Name: store_merge_unit

Overview:
- Memory-stage store path. It is the write side of the data-memory interface; the write-back stage only formats load data.
- Takes store requests from EX/MEM (word, halfword, byte) and aligns store data to the little-endian byte lane.
- Drives a word-wide synchronous data memory.
- Memory has no byte enables by default, so partial stores use a read-modify-write (RMW) sequence, with stall to the pipeline. Load addresses pass through in IDLE.

Parameters:
- AW, 10, data-memory word-address width; outMemAddr = inAddr[AW+1:2].

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- inMemWrite  in  1  store request, held by pipeline while outStall=1.
- inMemRead  in  1  load request.
- inStoreSize  in  2  00 word, 01 byte, 10 halfword, 11 reserved (treated as word).
- inAddr  in  32  byte address from ALU.
- inStoreData  in  32  rt value, data in low bits.
- inMemRd  in  32  memory read data, valid one cycle after address.
- outMemAddr  out  AW  word address to memory.
- outMemWe  out  1  memory write strobe.
- outMemWd  out  32  memory write data.
- outMemBe  out  4  byte enables; meaningful only with the optional feature, otherwise 4'hF.
- outStall  out  1  freeze PC/IF/ID/EX/MEM registers.
- outMisaligned  out  1  address exception pulse, store suppressed.

Behaviour:
- Reset (synchronous, rst=1 at edge): state=IDLE. Latched addr/data/size cleared.
- Outputs during and after reset until the next request: outMemWe=0, outStall=0, outMisaligned=0, outMemBe=4'hF, outMemWd=0, outMemAddr=inAddr[AW+1:2].
- States: IDLE, MERGE.
- IDLE, no request: outMemAddr=inAddr[AW+1:2], outMemWe=0.
- IDLE, inMemWrite=1, word size, aligned (inAddr[1:0]=00): outMemWe=1 and outMemWd=inStoreData in the same cycle. No stall; stay IDLE.
- IDLE, inMemWrite=1, byte, or halfword with inAddr[0]=0:
  - Cycle 0: issue read of the word address (outMemWe=0), outStall=1 combinationally.
  - Cycle 0: latch word address, lane=inAddr[1:0], size and data. Next state MERGE.
- MERGE (cycle 1): outMemAddr=latched address, outMemWe=1, outStall=0. Pipeline advances at the end of cycle 1. Next state IDLE.
- Merge rules:
  - Byte: lane byte of inMemRd replaced by inStoreData[7:0].
  - Halfword: lane bytes [lane+1:lane] replaced by inStoreData[15:0].
  - All other bytes come from inMemRd unchanged.
- Partial-store latency: 2 cycles; one stall cycle per partial store.
- Misaligned store:
  - Cases: word with inAddr[1:0]!=0, or halfword with inAddr[0]=1.
  - Response: outMisaligned=1 for that cycle, outMemWe=0, no stall, stay IDLE.
- inMemWrite and inMemRead both 1: write wins; read ignored.
- inMemRead in IDLE: address passthrough only; load data is consumed downstream.
- Back-to-back partial stores: MERGE returns to IDLE, and the next store starts on the following cycle. No request is accepted in MERGE, and inputs are ignored there.
- rst=1 in MERGE: write suppressed that cycle (outMemWe=0), state=IDLE. The memory word is unchanged.
- outMemWe is never asserted for more than one cycle per request.

Optional Feature:
- Macro: STORE_BYTE_ENABLE_EN.
- Defined: memory supports byte enables, so the RMW FSM is not used.
  - All aligned stores complete in 1 cycle from IDLE and outStall stays 0.
  - outMemWd = data replicated to every lane (byte x4, halfword x2).
  - outMemBe: byte → 1<<lane; halfword → 2'b11<<lane; word → 4'hF.
  - Misalignment handling unchanged.
- Undefined: RMW behaviour as above; outMemBe constant 4'hF.

Test Plan:
- Word 0x10=0xAABBCCDD; SB addr 0x11 data 0x12345677.
  - Cycle 0: stall=1, read word 4.
  - Cycle 1: We=1, Wd=0xAABB77DD.
  - Memory reads back 0xAABB77DD.
- Same word; SH addr 0x12 data 0x0000BEEF → written 0xBEEFCCDD; exactly one stall cycle.
- SW addr 0x14 data 0xDEADBEEF → We=1 in the same cycle, stall never asserted, word 5=0xDEADBEEF.
- SH addr 0x13 → outMisaligned=1 one cycle, We=0, word 4 unchanged. SW addr 0x16 → same response.
- SB 0x10 data 0x11 then SB 0x13 data 0x44, back to back, word initially 0 → final word 0x44000011; stall pattern 1,0,1,0.
- rst pulsed during MERGE of SB 0x10 → no write, word unchanged, all outputs at reset values the next cycle.
- With STORE_BYTE_ENABLE_EN: SB 0x12 data 0xAB → Be=4'b0100, Wd=0xABABABAB, stall=0.
